// File: rtl/cell_store_arbiter.sv
// cell_store_arbiter: arbitrates one 81 x 5-bit cell store between a display
// reader (absolute priority while bright=1) and a player write / grid clear
// engine that only touches the store on bright=0 cycles.
// Optional feature macro: GIVEN_LOCK_EN -- cells with bit 4 set are write
// protected and survive a grid clear.
module cell_store_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bright,
    input  logic [4:0] disp_i,
    input  logic [4:0] disp_j,
    output logic [4:0] disp_value,
    input  logic       wr_req,
    input  logic [4:0] wr_i,
    input  logic [4:0] wr_j,
    input  logic [4:0] wr_value,
    output logic       wr_ack,
    output logic       wr_err,
    input  logic       clr_req,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

    state_t     state_q;
    logic [4:0] mem_q [81];
    logic [6:0] wr_addr_q;
    logic [4:0] wr_data_q;
    logic [6:0] clr_idx_q;
    logic [4:0] disp_value_q;
    logic       wr_ack_q;
    logic       wr_err_q;
    logic       clr_pend_q;

    logic       mem_we_d;
    logic [6:0] mem_addr_d;
    logic [4:0] mem_data_d;
    logic       wr_locked;
    logic       clr_keep;

    function automatic logic in_range(input logic [4:0] i, input logic [4:0] j);
        return (i <= 5'd8) && (j <= 5'd8);
    endfunction

    function automatic logic [6:0] cell_idx(input logic [4:0] i, input logic [4:0] j);
        return {2'b00, i} * 7'd9 + {2'b00, j};
    endfunction

`ifdef GIVEN_LOCK_EN
    assign wr_locked = mem_q[wr_addr_q][4];
    assign clr_keep  = mem_q[clr_idx_q][4];
`else
    assign wr_locked = 1'b0;
    assign clr_keep  = 1'b0;
`endif

    assign disp_value = disp_value_q;
    assign wr_ack     = wr_ack_q;
    assign wr_err     = wr_err_q;
    assign busy       = (state_q != IDLE);

    // Single store write port; only driven on bright=0 cycles so it never collides with a display read
    always_comb begin
        mem_we_d   = 1'b0;
        mem_addr_d = '0;
        mem_data_d = '0;
        case (state_q)
            WRITE: begin
                if (wr_req && !bright && !wr_locked) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = wr_addr_q;
                    mem_data_d = wr_data_q;
                end
            end
            CLEAR: begin
                if (!bright && !clr_keep) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = clr_idx_q;
                    mem_data_d = '0;
                end
            end
            default: ;
        endcase
    end

    // Cell store: asynchronously zeroed, one write per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < 81; k++) mem_q[k] <= '0;
        end else if (mem_we_d) begin
            mem_q[mem_addr_d] <= mem_data_d;
        end
    end

    // Display read port: load on bright=1, hold otherwise, zero for off-grid coordinates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_value_q <= '0;
        end else if (bright) begin
            disp_value_q <= in_range(disp_i, disp_j) ? mem_q[cell_idx(disp_i, disp_j)] : '0;
        end
    end

    // Control FSM with registered ack/err pulses; a request is not re-sampled
    // during its own ack/err cycle so the requester has that cycle to drop it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            clr_idx_q  <= '0;
            wr_ack_q   <= 1'b0;
            wr_err_q   <= 1'b0;
            clr_pend_q <= 1'b0;
        end else begin
            wr_ack_q <= 1'b0;
            wr_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (clr_pend_q) begin
                        clr_pend_q <= 1'b0;
                        clr_idx_q  <= '0;
                        state_q    <= CLEAR;
                    end else if (wr_req && !wr_ack_q && !wr_err_q) begin
                        clr_pend_q <= clr_req;
                        if (in_range(wr_i, wr_j)) begin
                            wr_addr_q <= cell_idx(wr_i, wr_j);
                            wr_data_q <= wr_value;
                            state_q   <= WRITE;
                        end else begin
                            wr_err_q <= 1'b1;
                        end
                    end else if (clr_req) begin
                        clr_idx_q <= '0;
                        state_q   <= CLEAR;
                    end
                end
                WRITE: begin
                    if (!wr_req || !bright) begin
                        if (wr_req) begin
                            wr_ack_q <= !wr_locked;
                            wr_err_q <= wr_locked;
                        end
                        clr_pend_q <= 1'b0;
                        clr_idx_q  <= '0;
                        state_q    <= (clr_pend_q || clr_req) ? CLEAR : IDLE;
                    end else if (clr_req) begin
                        clr_pend_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (!bright) begin
                        if (clr_idx_q == 7'd80) begin
                            clr_idx_q <= '0;
                            state_q   <= IDLE;
                        end else begin
                            clr_idx_q <= clr_idx_q + 7'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/cell_store_arbiter.md
CELL_STORE_ARBITER -- requirements
Module: cell_store_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have port bright, input, 1, display active-region flag; high means the display owns the store port.
REQ-004 SHALL have ports disp_i / disp_j, input, 5 each, display read row/column (valid 0..8).
REQ-005 SHALL have port disp_value, output, 5, registered read data to the display.
REQ-006 SHALL have port wr_req, input, 1, player write request; held high until wr_ack or wr_err.
REQ-007 SHALL have ports wr_i / wr_j, input, 5 each, write row/column.
REQ-008 SHALL have port wr_value, input, 5; bit 4 is the given flag and bits 3:0 are the digit 0..9.
REQ-009 SHALL have port wr_ack, output, 1, one-cycle pulse when a write commits.
REQ-010 SHALL have port wr_err, output, 1, one-cycle pulse when a write is rejected.
REQ-011 SHALL have port clr_req, input, 1, pulse that starts a grid clear.
REQ-012 SHALL have port busy, output, 1, high while a write is pending or a clear is running.

Function
REQ-013 SHALL hold an internal 81 x 5-bit cell store at index i*9+j, with exactly one access (read or write) per cycle.
REQ-014 SHALL read cell (disp_i, disp_j) into disp_value one cycle later on every bright=1 cycle; display reads have absolute priority.
REQ-015 SHALL hold disp_value on bright=0 cycles, and SHALL load 0 when disp_i>8 or disp_j>8.
REQ-016 SHALL use FSM states IDLE, WRITE and CLEAR; only bright=0 cycles may perform a write.
REQ-017 IDLE -> WRITE: wr_req=1 is sampled; WRITE commits on the first bright=0 cycle, pulses wr_ack the next cycle, then returns to IDLE.
REQ-018 A write with wr_i>8 or wr_j>8 SHALL pulse wr_err one cycle after it is sampled, modify nothing, and return to IDLE.
REQ-019 If wr_req drops before commit, the write SHALL be withdrawn with no store change, no ack, and return to IDLE.
REQ-020 IDLE -> CLEAR on clr_req; if clr_req arrives while a write is pending, the write SHALL finish first and the clear SHALL start next.
REQ-021 CLEAR SHALL step an index counter 0..80, writing one cell per bright=0 cycle and pausing while bright=1; after index 80 it returns to IDLE.
REQ-022 clr_req SHALL be ignored while in CLEAR; wr_req during CLEAR SHALL wait and be served after the clear.
REQ-023 busy SHALL be high in WRITE and CLEAR and low in IDLE.

Reset
REQ-024 rst_n=0 SHALL immediately set all cells to 0, disp_value=0, wr_ack=0, wr_err=0, busy=0, state IDLE and clear index 0.
REQ-025 A reset during WRITE or CLEAR SHALL abort the operation with no ack; the store is fully zeroed.

Configuration
REQ-026 With GIVEN_LOCK_EN defined, a write to a cell whose stored bit 4 = 1 SHALL pulse wr_err, leave the cell unchanged, and CLEAR SHALL zero only cells with bit 4 = 0.
REQ-027 Without GIVEN_LOCK_EN, bit 4 SHALL be plain data, all in-range writes SHALL commit, and CLEAR SHALL zero every cell.

Verification
REQ-028 Read after write: bright=0; write (2,4)=5'h07 -> wr_ack pulses; then bright=1, disp_i=2, disp_j=4 -> disp_value=5'h07 the next cycle.
REQ-029 Display priority: bright=1 held 20 cycles with wr_req (0,0)=5'h03 -> no ack while bright=1; ack within 2 cycles of bright falling to 0.
REQ-030 Range error: write to (9,0) -> wr_err pulses once, no wr_ack; read of (9,0) returns 0.
REQ-031 Paused clear: fill all cells with 5'h01, pulse clr_req, toggle bright every 10 cycles -> busy stays high for exactly 81 bright=0 cycles; all cells then read 0.
REQ-032 Given lock (GIVEN_LOCK_EN): cell (4,4)=5'h15; write (4,4)=5'h02 -> wr_err and the cell stays 5'h15; clear -> (4,4) still 5'h15 and others 0.
REQ-033 Reset mid-clear: assert rst_n=0 at clear index 40 -> busy=0 immediately, all cells 0, no wr_ack.
